// File: rtl/route_reserve_allocator.sv
// rtl/route_reserve_allocator.sv - per-output route reservation arbiter with crossbar selects (ROUND_ROBIN_EN selects round-robin arbitration)
module route_reserve_allocator #(
    parameter int PORTS         = 4,
    parameter int REQUEST_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PORTS-1:0]                 req_valid_i,
    input  logic [PORTS*REQUEST_WIDTH-1:0]   req_port_i,
    input  logic [PORTS-1:0]                 release_i,
    output logic [PORTS-1:0]                 grant_status_o,
    output logic [PORTS-1:0]                 out_busy_o,
    output logic [PORTS*REQUEST_WIDTH-1:0]   xbar_sel_o
);
    localparam int RW = REQUEST_WIDTH;

    localparam logic [0:0] ST_FREE     = 1'b0;
    localparam logic [0:0] ST_RESERVED = 1'b1;

    // Per-output reservation state and owning input
    logic [0:0]       state_q [PORTS];
    logic [0:0]       state_d [PORTS];
    logic [RW-1:0]    owner_q [PORTS];
    logic [RW-1:0]    owner_d [PORTS];
    // Per-input: currently holds an output / status pulse for this cycle
    logic [PORTS-1:0] held_q;
    logic [PORTS-1:0] held_d;
    logic [PORTS-1:0] grant_q;
    logic [PORTS-1:0] grant_d;
`ifdef ROUND_ROBIN_EN
    // Per-output search start, advanced past the owner on release
    logic [RW-1:0]    rr_q [PORTS];
    logic [RW-1:0]    rr_d [PORTS];
`endif

    int   arb_base;
    int   arb_idx;
    logic arb_found;

    // Release handling and per-output arbitration; both read only registered state,
    // so an output released this cycle is not re-arbitrated until the next one
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        held_d    = held_q;
        grant_d   = '0;
        arb_base  = 0;
        arb_idx   = 0;
        arb_found = 1'b0;
`ifdef ROUND_ROBIN_EN
        rr_d      = rr_q;
`endif
        for (int o = 0; o < PORTS; o++) begin
            if (state_q[o] == ST_RESERVED) begin
                // Only the owning input can free a reserved output
                for (int i = 0; i < PORTS; i++) begin
                    if (owner_q[o] == RW'(i) && release_i[i]) begin
                        state_d[o] = ST_FREE;
                        held_d[i]  = 1'b0;
`ifdef ROUND_ROBIN_EN
                        rr_d[o]    = RW'((i + 1) % PORTS);
`endif
                    end
                end
            end else begin
`ifdef ROUND_ROBIN_EN
                arb_base  = int'(rr_q[o]);
`else
                arb_base  = 0;
`endif
                arb_found = 1'b0;
                for (int k = 0; k < PORTS; k++) begin
                    arb_idx = arb_base + k;
                    if (arb_idx >= PORTS) begin
                        arb_idx = arb_idx - PORTS;
                    end
                    // Out-of-range requests never equal any o, so they are never granted
                    if (!arb_found && req_valid_i[arb_idx] && !held_q[arb_idx] &&
                        req_port_i[arb_idx*RW +: RW] == RW'(o)) begin
                        arb_found        = 1'b1;
                        state_d[o]       = ST_RESERVED;
                        owner_d[o]       = RW'(arb_idx);
                        held_d[arb_idx]  = 1'b1;
                        grant_d[arb_idx] = 1'b1;
                    end
                end
            end
        end
    end

    // Register all reservation state; reset drops reservations and pending pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < PORTS; o++) begin
                state_q[o] <= ST_FREE;
                owner_q[o] <= '0;
`ifdef ROUND_ROBIN_EN
                rr_q[o]    <= '0;
`endif
            end
            held_q  <= '0;
            grant_q <= '0;
        end else begin
            for (int o = 0; o < PORTS; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
`ifdef ROUND_ROBIN_EN
                rr_q[o]    <= rr_d[o];
`endif
            end
            held_q  <= held_d;
            grant_q <= grant_d;
        end
    end

    // Outputs come straight from registers; xbar_sel keeps the last owner after release
    always_comb begin
        grant_status_o = grant_q;
        out_busy_o     = '0;
        xbar_sel_o     = '0;
        for (int o = 0; o < PORTS; o++) begin
            out_busy_o[o]            = (state_q[o] == ST_RESERVED);
            xbar_sel_o[o*RW +: RW]   = owner_q[o];
        end
    end

endmodule
